// File: rtl/alu_req_arbiter_pkg.sv
// Shared types and widths for the ALU request arbiter: ALU opcode enums,
// operand/result widths and the arbiter FSM state encoding.
package alu_req_arbiter_pkg;

    localparam int A_OP_WIDTH   = 3;
    localparam int B_OP_WIDTH   = 2;
    localparam int INPUT_WIDTH  = 5;
    localparam int OUTPUT_WIDTH = 6;

    // 2'b10 is deliberately unassigned and is rejected as an illegal mode.
    typedef enum logic [1:0] {
        MODE_A   = 2'b00,
        MODE_B01 = 2'b01,
        MODE_B11 = 2'b11
    } OP_MODE_t;

    typedef enum logic [A_OP_WIDTH-1:0] {
        A_AND  = 3'd0,
        A_NAND = 3'd1,
        A_OR   = 3'd2,
        A_NOR  = 3'd3,
        A_XOR  = 3'd4,
        A_XNOR = 3'd5,
        A_ADD  = 3'd6,
        A_SUB  = 3'd7
    } OP_A_t;

    typedef enum logic [B_OP_WIDTH-1:0] {
        B01_NOT_A = 2'd0,
        B01_NOT_B = 2'd1,
        B01_NAND  = 2'd2,
        B01_NOR   = 2'd3
    } OP_B01_t;

    typedef enum logic [B_OP_WIDTH-1:0] {
        B11_A_ADD_1 = 2'd0,
        B11_A_SUB_1 = 2'd1,
        B11_B_ADD_1 = 2'd2,
        B11_B_SUB_1 = 2'd3
    } OP_B11_t;

    typedef enum logic {
        ALU_OFF = 1'b0,
        ALU_ON  = 1'b1
    } ALU_EN_STATE_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;

    function automatic logic mode_is_legal(input logic [1:0] mode);
        logic legal;
        case (mode)
            MODE_A, MODE_B01, MODE_B11: legal = 1'b1;
            default:                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    int   w_pos;
    logic w_hit;
    logic w_found;

    // Scan from the pointer; only the first hit may set a grant bit.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_hit   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos          = (int'(i_ptr) + k) % NUM_REQ;
            w_hit          = !w_found && i_req[w_pos];
            o_grant[w_pos] = w_hit;
            o_idx          = w_hit ? ID_W'(w_pos) : o_idx;
            w_found        = w_found | w_hit;
        end
        o_any = w_found;
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one external ALU between NUM_REQ requesters: round-robin grant,
// one-cycle issue, fixed-latency wait, then a valid/ready response.
module alu_req_arbiter
    import alu_req_arbiter_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int ALU_LATENCY = 1,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [2*NUM_REQ-1:0]              req_mode,
    input  logic [A_OP_WIDTH*NUM_REQ-1:0]     req_a_op,
    input  logic [B_OP_WIDTH*NUM_REQ-1:0]     req_b_op,
    input  logic [INPUT_WIDTH*NUM_REQ-1:0]    req_a,
    input  logic [INPUT_WIDTH*NUM_REQ-1:0]    req_b,
    output logic                              alu_en,
    output logic [1:0]                        alu_mode,
    output logic [A_OP_WIDTH-1:0]             alu_a_op,
    output logic [B_OP_WIDTH-1:0]             alu_b_op,
    output logic [INPUT_WIDTH-1:0]            alu_a,
    output logic [INPUT_WIDTH-1:0]            alu_b,
    input  logic [OUTPUT_WIDTH-1:0]           alu_result,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [ID_W-1:0]                   resp_id,
    output logic [OUTPUT_WIDTH-1:0]           resp_result,
    output logic                              resp_err
);

    localparam int CNT_W = 2;

    arb_state_t               r_state;
    arb_state_t               w_next;
    logic [ID_W-1:0]          r_rr_ptr;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_alu_en;
    logic [1:0]               r_alu_mode;
    logic [A_OP_WIDTH-1:0]    r_alu_a_op;
    logic [B_OP_WIDTH-1:0]    r_alu_b_op;
    logic [INPUT_WIDTH-1:0]   r_alu_a;
    logic [INPUT_WIDTH-1:0]   r_alu_b;
    logic                     r_resp_valid;
    logic [ID_W-1:0]          r_resp_id;
    logic [OUTPUT_WIDTH-1:0]  r_resp_result;
    logic                     r_resp_err;

    logic [NUM_REQ-1:0]       w_grant;
    logic [ID_W-1:0]          w_idx;
    logic                     w_any;
    logic                     w_idle;
    logic                     w_legal;
    logic [ID_W-1:0]          w_ptr_next;
    logic [1:0]               w_sel_mode;
    logic [A_OP_WIDTH-1:0]    w_sel_a_op;
    logic [B_OP_WIDTH-1:0]    w_sel_b_op;
    logic [INPUT_WIDTH-1:0]   w_sel_a;
    logic [INPUT_WIDTH-1:0]   w_sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_idle     = (r_state == IDLE);
    assign req_ready  = w_grant & {NUM_REQ{w_idle}};
    assign w_sel_mode = req_mode[2*int'(w_idx) +: 2];
    assign w_sel_a_op = req_a_op[A_OP_WIDTH*int'(w_idx) +: A_OP_WIDTH];
    assign w_sel_b_op = req_b_op[B_OP_WIDTH*int'(w_idx) +: B_OP_WIDTH];
    assign w_sel_a    = req_a[INPUT_WIDTH*int'(w_idx) +: INPUT_WIDTH];
    assign w_sel_b    = req_b[INPUT_WIDTH*int'(w_idx) +: INPUT_WIDTH];
    assign w_legal    = mode_is_legal(w_sel_mode);
    assign w_ptr_next = (w_idx == ID_W'(NUM_REQ-1)) ? ID_W'(0) : w_idx + ID_W'(1);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; an illegal mode skips the ALU and answers directly.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = w_legal ? ISSUE : RESP;
                end else begin
                    w_next = IDLE;
                end
            end
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = (r_cnt == CNT_W'(0)) ? RESP : WAIT;
            RESP:    w_next = resp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // Capture, latency counter and response registers; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_cnt         <= '0;
            r_alu_en      <= 1'b0;
            r_alu_mode    <= '0;
            r_alu_a_op    <= '0;
            r_alu_b_op    <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_rr_ptr  <= w_ptr_next;
                        r_resp_id <= w_idx;
                        if (w_legal) begin
                            r_alu_en   <= ALU_ON;
                            r_alu_mode <= w_sel_mode;
                            r_alu_a_op <= w_sel_a_op;
                            r_alu_b_op <= w_sel_b_op;
                            r_alu_a    <= w_sel_a;
                            r_alu_b    <= w_sel_b;
                        end else begin
                            r_resp_valid  <= 1'b1;
                            r_resp_err    <= 1'b1;
                            r_resp_result <= '0;
                        end
                    end
                end
                ISSUE: begin
                    r_alu_en <= ALU_OFF;
                    r_cnt    <= CNT_W'(ALU_LATENCY-1);
                end
                WAIT: begin
                    if (r_cnt == CNT_W'(0)) begin
                        r_resp_valid  <= 1'b1;
                        r_resp_err    <= 1'b0;
                        r_resp_result <= alu_result;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_alu_en     <= ALU_OFF;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign alu_en      = r_alu_en;
    assign alu_mode    = r_alu_mode;
    assign alu_a_op    = r_alu_a_op;
    assign alu_b_op    = r_alu_b_op;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_err    = r_resp_err;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized scoreboard bench for alu_req_arbiter with a behavioural ALU and
// a reference model of grant order, latency and responses.
module tb_alu_req_arbiter;
    import alu_req_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid, req_ready;
    logic [2*N-1:0]   req_mode;
    logic [3*N-1:0]   req_a_op;
    logic [2*N-1:0]   req_b_op;
    logic [5*N-1:0]   req_a, req_b;
    logic             alu_en;
    logic [1:0]       alu_mode;
    logic [2:0]       alu_a_op;
    logic [1:0]       alu_b_op;
    logic [4:0]       alu_a, alu_b;
    logic [5:0]       alu_result;
    logic             resp_valid, resp_ready;
    logic [IDW-1:0]   resp_id;
    logic [5:0]       resp_result;
    logic             resp_err;

    always #5 clk = ~clk;

    alu_req_arbiter #(.NUM_REQ(N), .ALU_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_a_op(req_a_op), .req_b_op(req_b_op),
        .req_a(req_a), .req_b(req_b), .alu_en(alu_en), .alu_mode(alu_mode),
        .alu_a_op(alu_a_op), .alu_b_op(alu_b_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result), .resp_err(resp_err)
    );

    // Requester-side state driven by the stimulus process
    logic [N-1:0] tv;
    logic [1:0]   t_mode [N];
    logic [2:0]   t_aop  [N];
    logic [1:0]   t_bop  [N];
    logic [4:0]   t_a    [N];
    logic [4:0]   t_b    [N];

    always_comb begin
        req_valid = tv;
        req_mode = '0; req_a_op = '0; req_b_op = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_mode[2*i +: 2] = t_mode[i];
            req_a_op[3*i +: 3] = t_aop[i];
            req_b_op[2*i +: 2] = t_bop[i];
            req_a[5*i +: 5]    = t_a[i];
            req_b[5*i +: 5]    = t_b[i];
        end
    end

    function automatic logic [5:0] alu_ref(input logic [1:0] m, input logic [2:0] ao,
                                           input logic [1:0] bo, input logic [4:0] a,
                                           input logic [4:0] b);
        logic [5:0] x, y;
        x = {a[4], a};
        y = {b[4], b};
        case (m)
            2'b00: case (ao)
                A_AND:   return x & y;
                A_NAND:  return ~(x & y);
                A_OR:    return x | y;
                A_NOR:   return ~(x | y);
                A_XOR:   return x ^ y;
                A_XNOR:  return ~(x ^ y);
                A_ADD:   return x + y;
                default: return x - y;
            endcase
            2'b01: case (bo)
                B01_NOT_A: return ~x;
                B01_NOT_B: return ~y;
                B01_NAND:  return ~(x & y);
                default:   return ~(x | y);
            endcase
            2'b11: case (bo)
                B11_A_ADD_1: return x + 6'd1;
                B11_A_SUB_1: return x - 6'd1;
                B11_B_ADD_1: return y + 6'd1;
                default:     return y - 6'd1;
            endcase
            default: return 6'd0;
        endcase
    endfunction

    // Behavioural ALU: result appears LAT edges after the issue edge; garbage otherwise.
    logic [5:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= alu_en ? alu_ref(alu_mode, alu_a_op, alu_b_op, alu_a, alu_b) : 6'($urandom);
        for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
    end
    assign alu_result = pipe[LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         id;
        logic [5:0] res;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t        sbq[$];
    int          grant_log[$];
    logic [N-1:0] acc = '0;
    bit          model_idle = 1'b1;
    bit          after_rst  = 1'b0;
    int          ptr        = 0;
    int          issue_cyc  = -1;
    logic [16:0] issue_f;
    int          pops = 0;
    int          last_id;
    logic [5:0]  last_res;
    logic        last_err;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Monitor and reference model, sampled away from the active edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        bit           exp_rv;
        int           g;
        exp_t         e;
        if (rst) begin
            sbq.delete();
            model_idle = 1'b1;
            ptr        = 0;
            issue_cyc  = -1;
            after_rst  = 1'b1;
        end else begin
            if (after_rst) begin
                chk("reset_outputs", {alu_en, alu_mode, alu_a_op, alu_b_op, alu_a, alu_b,
                                      resp_valid, resp_id, resp_result, resp_err}, 0);
                after_rst = 1'b0;
            end
            exp_ready = '0;
            g = pick(tv, ptr);
            if (model_idle && g >= 0) exp_ready[g] = 1'b1;
            chk("req_ready", req_ready, exp_ready);
            if (exp_ready != '0) begin
                e.id  = g;
                e.err = (t_mode[g] == 2'b10);
                e.res = e.err ? 6'd0 : alu_ref(t_mode[g], t_aop[g], t_bop[g], t_a[g], t_b[g]);
                e.cyc = cyc + (e.err ? 1 : LAT + 2);
                sbq.push_back(e);
                issue_cyc  = e.err ? -1 : cyc + 1;
                issue_f    = {t_mode[g], t_aop[g], t_bop[g], t_a[g], t_b[g]};
                ptr        = (g + 1) % N;
                model_idle = 1'b0;
                acc[g]     = 1'b1;
                grant_log.push_back(g);
            end
            chk("alu_en", alu_en, cyc == issue_cyc);
            if (alu_en && cyc == issue_cyc)
                chk("alu_fields", {alu_mode, alu_a_op, alu_b_op, alu_a, alu_b}, issue_f);
            exp_rv = (sbq.size() > 0) && (cyc >= sbq[0].cyc);
            chk("resp_valid", resp_valid, exp_rv);
            if (exp_rv && resp_valid) begin
                chk("resp_id", resp_id, sbq[0].id);
                chk("resp_result", resp_result, sbq[0].res);
                chk("resp_err", resp_err, sbq[0].err);
                if (resp_ready) begin
                    last_id  = int'(resp_id);
                    last_res = resp_result;
                    last_err = resp_err;
                    void'(sbq.pop_front());
                    pops++;
                    model_idle = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                acc[i] = 1'b0;
                tv[i]  = 1'b0;
            end
        end
    endtask

    task automatic set_op(input int i, input logic [1:0] m, input logic [2:0] ao,
                          input logic [1:0] bo, input logic [4:0] a, input logic [4:0] b);
        t_mode[i] = m; t_aop[i] = ao; t_bop[i] = bo; t_a[i] = a; t_b[i] = b;
        tv[i] = 1'b1;
    endtask

    task automatic rand_op(input int i, input bit allow_illegal);
        int m;
        m = $urandom_range(0, 2);
        if (allow_illegal && $urandom_range(0, 9) == 0) m = 3;
        set_op(i, (m == 0) ? 2'b00 : (m == 1) ? 2'b01 : (m == 2) ? 2'b11 : 2'b10,
               3'($urandom), 2'($urandom), 5'($urandom), 5'($urandom));
    endtask

    task automatic wait_pops(input int target);
        int bud = 0;
        while (pops < target && bud < 100) begin tick(); bud++; end
        if (pops < target) chk("resp_timeout", pops, target);
    endtask

    task automatic drain();
        int bud = 0;
        resp_ready = 1'b1;
        while ((tv != '0 || sbq.size() > 0 || !model_idle) && bud < 300) begin tick(); bud++; end
        if (bud >= 300) chk("drain_timeout", bud, 0);
    endtask

    initial begin
        int start, bud, p;
        tv = '0;
        for (int i = 0; i < N; i++) begin
            t_mode[i] = 2'b00; t_aop[i] = 3'd0; t_bop[i] = 2'd0; t_a[i] = 5'd0; t_b[i] = 5'd0;
        end
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // All requesters held valid: strict rotation from pointer 0
        for (int i = 0; i < N; i++) rand_op(i, 1'b0);
        start = grant_log.size();
        bud = 0;
        while (grant_log.size() - start < 8 && bud < 400) begin
            tick(); bud++;
            if (grant_log.size() - start < 8)
                for (int i = 0; i < N; i++) if (!tv[i]) rand_op(i, 1'b0);
        end
        tv = '0;
        if (grant_log.size() - start < 8) chk("rotation_timeout", grant_log.size() - start, 8);
        else for (int j = 0; j < 8; j++) chk("grant_order", grant_log[start + j], j % 4);
        drain();

        // Single add from req0
        p = pops;
        set_op(0, MODE_A, A_ADD, 2'd0, 5'd5, 5'd3);
        wait_pops(p + 1);
        chk("add_id", last_id, 0);
        chk("add_result", last_res, 8);
        drain();

        // Decrement with back-pressure; req3 waits meanwhile
        p = pops;
        resp_ready = 1'b0;
        set_op(1, MODE_B11, 3'd0, B11_A_SUB_1, 5'b10000, 5'd7);
        rand_op(3, 1'b0);
        bud = 0;
        while (!resp_valid && bud < 50) begin tick(); bud++; end
        repeat (5) tick();
        resp_ready = 1'b1;
        wait_pops(p + 1);
        chk("sub1_result", last_res, 6'b101111);
        chk("sub1_id", last_id, 1);
        drain();

        // Illegal mode from req2
        p = pops;
        set_op(2, 2'b10, 3'd1, 2'd1, 5'd9, 5'd4);
        wait_pops(p + 1);
        chk("err_id", last_id, 2);
        chk("err_result", last_res, 0);
        chk("err_flag", last_err, 1);
        drain();

        // Reset while waiting on the ALU, then req3 alone
        set_op(1, MODE_A, A_XOR, 2'd0, 5'd11, 5'd6);
        bud = 0;
        while (tv[1] && bud < 50) begin tick(); bud++; end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(3, MODE_A, A_OR, 2'd0, 5'd2, 5'd1);
        bud = 0;
        while (tv[3] && bud < 50) begin tick(); bud++; end
        chk("post_reset_grant", grant_log[grant_log.size() - 1], 3);
        drain();

        // NAND of zeros gives all ones
        p = pops;
        set_op(0, MODE_B01, 3'd0, B01_NAND, 5'd0, 5'd0);
        wait_pops(p + 1);
        chk("nand_result", last_res, 6'b111111);
        drain();

        // Random traffic with random back-pressure and occasional illegal modes
        for (int c = 0; c < 500; c++) begin
            tick();
            for (int i = 0; i < N; i++) if (!tv[i] && $urandom_range(0, 2) == 0) rand_op(i, 1'b1);
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        tv = '0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
